aurora_axis_tx_arb: RTL and testbench
=====================================

// Module: aurora_axis_tx_arb
// PURPOSE
//  Packet-aware N:1 AXI-Stream multiplexer feeding the Aurora TX user interface.
//  Grants one source per packet and holds the grant until the accepted beat carrying tlast.
//  Two modes: round-robin arbitration, or external select sampled only at packet boundaries.
//  A registered output stage sustains full throughput under backpressure.
//  Sits between per-channel framers and the Aurora core TX port.
// PARAMETERS
//  CH_COUNT  4        number of slave channels, 2..16
//  DATA_W    32       tdata width in bits, multiple of 8
//  KEEP_W    DATA_W/8 tkeep width (derived; do not override)
//  SEL_W     2        select/tid width, >= clog2(CH_COUNT)
//  MODE      0        0 = round-robin; 1 = external select via axis_s_sel
// PORTS
//  clk            in   1               single clock for all logic
//  rstn           in   1               synchronous reset, active-low
//  axis_s_sel     in   SEL_W           channel select, used only when MODE=1
//  axis_s_tready  out  CH_COUNT        per-channel ready
//  axis_s_tdata   in   CH_COUNT*DATA_W channel i occupies [i*DATA_W +: DATA_W]
//  axis_s_tkeep   in   CH_COUNT*KEEP_W channel i occupies [i*KEEP_W +: KEEP_W]
//  axis_s_tvalid  in   CH_COUNT        per-channel valid
//  axis_s_tlast   in   CH_COUNT        per-channel end of packet
//  axis_m_tready  in   1               downstream ready
//  axis_m_tdata   out  DATA_W          registered data
//  axis_m_tkeep   out  KEEP_W          registered keep
//  axis_m_tvalid  out  1               registered valid
//  axis_m_tlast   out  1               registered last
//  axis_m_tid     out  SEL_W           source channel of the current output beat
//  busy           out  1               high while a packet grant is held
// BEHAVIOUR
//  - Reset (rstn=0 at a clk edge): all registered outputs go to 0, FSM goes to IDLE,
//    grant pointer goes to CH_COUNT-1 so channel 0 wins first. axis_s_tready is
//    all-zero while rstn=0.
//  - A reset mid-packet drops the packet. The tail beats are then treated as a new packet.
//  - FSM states: IDLE, PKT.
//  - IDLE: evaluate requests; no tready is asserted.
//      MODE 0: grant the first channel with tvalid=1, searching upward (mod CH_COUNT)
//        from last_grant+1.
//      MODE 1: grant axis_s_sel when sel < CH_COUNT and tvalid[sel]=1. Otherwise stay in IDLE.
//      On a grant: latch gnt and go to PKT on the next cycle. This costs one bubble
//        cycle between packets.
//  - PKT: ld = ~axis_m_tvalid | axis_m_tready.
//      axis_s_tready[gnt] = ld; all other tready bits are 0. The ld path is
//        combinational from axis_m_tready.
//      A beat is accepted when tvalid[gnt] & tready[gnt]. On acceptance, register
//        tdata/tkeep/tlast of gnt into axis_m_*, set tvalid=1 and tid=gnt.
//      If ld=1 and no beat is accepted, set axis_m_tvalid <= 0 (the previous beat drains).
//      When the accepted beat has tlast=1: go to IDLE, set last_grant = gnt, busy falls next cycle.
//  - In IDLE, the output register still drains: when axis_m_tready=1, axis_m_tvalid <= 0.
//  - While axis_m_tvalid=1 and axis_m_tready=0, axis_m_* hold stable (AXIS rule).
//  - Latency: 1 clk from slave acceptance to output valid. Throughput is 1 beat/clk inside a packet.
//  - Select changes during PKT are ignored. An out-of-range sel never produces a grant.
//  - A channel dropping tvalid mid-packet keeps the grant; the block waits with no timeout.
//  - busy = (state == PKT).
// STRUCTURE
//  - aurora_defs.vh (shared include): FSM state localparams, AXIS_KEEP_W(w) macro,
//    clog2 constant function.
//  - Sub-module aurora_rr_arb: combinational round-robin pick.
//      Inputs: req[CH_COUNT], last[SEL_W]. Outputs: gnt[SEL_W], any.
//      Instantiated only when MODE=0.
//  - Top level holds the FSM, the grant register and the output register (~200 lines).
// TESTING
//  1 Reset: hold rstn=0 for 3 clk with all tvalid=1 -> all outputs 0, tready=0;
//    first grant after release goes to ch0.
//  2 RR fairness: MODE0, CH_COUNT=4, every channel sends 3-beat packets continuously
//    -> axis_m_tid sequence is 0,1,2,3,0..., no beat interleaving,
//    exactly one idle cycle between packets.
//  3 Backpressure: axis_m_tready toggles 1,0,0,1 during a 5-beat packet
//    -> 5 beats out in order, data stable while stalled, no loss or duplication.
//  4 Select mode: MODE1, sel=2 while a packet is in flight, changed to 1 mid-packet
//    -> the ch2 packet completes, then ch1 is granted; sel=3 with CH_COUNT=3 -> no grant.
//  5 Single-beat packets: tlast=1 on every beat from ch1 only
//    -> one beat every 2 clk, tid=1, tlast=1 on each output beat.
//  6 Reset mid-packet: rstn=0 on beat 2 of 4
//    -> outputs clear next clk; after release, the remaining beats form a new grant;
//    the scoreboard flags the truncated packet.

Source files
------------

// File: rtl/aurora_axis_tx_arb_pkg.sv
// rtl/aurora_axis_tx_arb_pkg.sv - shared types and helpers for the Aurora TX arbiter
package aurora_axis_tx_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } arb_state_e;

  function automatic int axis_keep_w(input int data_w);
    return data_w / 8;
  endfunction

  // Channel reached by stepping 'off' places upward from 'last', wrapping at ch_count.
  function automatic int rr_index(input int last, input int off, input int ch_count);
    return (last + off) % ch_count;
  endfunction

endpackage

// File: rtl/aurora_axis_tx_arb_if.sv
// rtl/aurora_axis_tx_arb_if.sv - channel and output stream bundle for the Aurora TX arbiter
interface aurora_axis_tx_arb_if #(
  parameter int CH_COUNT = 4,
  parameter int DATA_W   = 32,
  parameter int SEL_W    = 2
);
  import aurora_axis_tx_arb_pkg::*;
  localparam int KEEP_W = axis_keep_w(DATA_W);

  logic [SEL_W-1:0]           axis_s_sel;
  logic [CH_COUNT-1:0]        axis_s_tready;
  logic [CH_COUNT*DATA_W-1:0] axis_s_tdata;
  logic [CH_COUNT*KEEP_W-1:0] axis_s_tkeep;
  logic [CH_COUNT-1:0]        axis_s_tvalid;
  logic [CH_COUNT-1:0]        axis_s_tlast;
  logic                       axis_m_tready;
  logic [DATA_W-1:0]          axis_m_tdata;
  logic [KEEP_W-1:0]          axis_m_tkeep;
  logic                       axis_m_tvalid;
  logic                       axis_m_tlast;
  logic [SEL_W-1:0]           axis_m_tid;
  logic                       busy;

  // Arbiter side.
  modport slave (
    input  axis_s_sel, axis_s_tdata, axis_s_tkeep, axis_s_tvalid, axis_s_tlast, axis_m_tready,
    output axis_s_tready, axis_m_tdata, axis_m_tkeep, axis_m_tvalid, axis_m_tlast, axis_m_tid, busy
  );

  // Framer / Aurora core side.
  modport master (
    output axis_s_sel, axis_s_tdata, axis_s_tkeep, axis_s_tvalid, axis_s_tlast, axis_m_tready,
    input  axis_s_tready, axis_m_tdata, axis_m_tkeep, axis_m_tvalid, axis_m_tlast, axis_m_tid, busy
  );

endinterface

// File: rtl/aurora_axis_tx_arb_rr_arb.sv
// rtl/aurora_axis_tx_arb_rr_arb.sv - combinational round-robin pick starting after the last grant
module aurora_rr_arb
  import aurora_axis_tx_arb_pkg::*;
#(
  parameter int CH_COUNT = 4,
  parameter int SEL_W    = 2
) (
  input  logic [CH_COUNT-1:0] req,
  input  logic [SEL_W-1:0]    last,
  output logic [SEL_W-1:0]    gnt,
  output logic                any
);

  // Walk offsets from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int off = CH_COUNT; off >= 1; off--) begin
      for (int i = 0; i < CH_COUNT; i++) begin
        if (req[i] && (rr_index(int'(last), off, CH_COUNT) == i)) begin
          gnt = SEL_W'(i);
          any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/aurora_axis_tx_arb.sv
// rtl/aurora_axis_tx_arb.sv - packet-aware N:1 AXI-Stream mux with registered output for Aurora TX
module aurora_axis_tx_arb #(
  parameter int CH_COUNT = 4,
  parameter int DATA_W   = 32,
  parameter int SEL_W    = 2,
  parameter int MODE     = 0
) (
  input logic                 clk,
  input logic                 rstn,
  aurora_axis_tx_arb_if.slave bus
);
  import aurora_axis_tx_arb_pkg::*;
  localparam int KEEP_W = axis_keep_w(DATA_W);

  arb_state_e        state_q, state_d;
  logic [SEL_W-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0]  last_q, last_d;
  logic [SEL_W-1:0]  pick;
  logic              pick_any;
  logic              ld;
  logic              accept;
  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep;
  logic              sel_valid;
  logic              sel_last;

  generate
    if (MODE == 0) begin : g_rr
      logic unused_sel;
      assign unused_sel = ^bus.axis_s_sel;
      aurora_rr_arb #(
        .CH_COUNT(CH_COUNT),
        .SEL_W   (SEL_W)
      ) u_rr (
        .req (bus.axis_s_tvalid),
        .last(last_q),
        .gnt (pick),
        .any (pick_any)
      );
    end else begin : g_ext
      // An out-of-range select matches no channel and so never grants.
      always_comb begin
        pick     = bus.axis_s_sel;
        pick_any = 1'b0;
        for (int i = 0; i < CH_COUNT; i++) begin
          if (bus.axis_s_sel == SEL_W'(i)) pick_any = bus.axis_s_tvalid[i];
        end
      end
    end
  endgenerate

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < CH_COUNT; i++) begin
      if (gnt_q == SEL_W'(i)) begin
        sel_data  = bus.axis_s_tdata[i*DATA_W +: DATA_W];
        sel_keep  = bus.axis_s_tkeep[i*KEEP_W +: KEEP_W];
        sel_valid = bus.axis_s_tvalid[i];
        sel_last  = bus.axis_s_tlast[i];
      end
    end
  end

  // Output register may take a new beat when empty or draining this cycle.
  assign ld     = ~bus.axis_m_tvalid | bus.axis_m_tready;
  assign accept = (state_q == ST_PKT) && sel_valid && ld;

  always_comb begin
    bus.axis_s_tready = '0;
    if (rstn && (state_q == ST_PKT)) begin
      for (int i = 0; i < CH_COUNT; i++) begin
        if (gnt_q == SEL_W'(i)) bus.axis_s_tready[i] = ld;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick;
          state_d = ST_PKT;
        end
      end
      ST_PKT: begin
        if (accept && sel_last) begin
          state_d = ST_IDLE;
          last_d  = gnt_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= SEL_W'(CH_COUNT - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.axis_m_tdata  <= '0;
      bus.axis_m_tkeep  <= '0;
      bus.axis_m_tvalid <= 1'b0;
      bus.axis_m_tlast  <= 1'b0;
      bus.axis_m_tid    <= '0;
    end else if (accept) begin
      bus.axis_m_tdata  <= sel_data;
      bus.axis_m_tkeep  <= sel_keep;
      bus.axis_m_tvalid <= 1'b1;
      bus.axis_m_tlast  <= sel_last;
      bus.axis_m_tid    <= gnt_q;
    end else if (ld) begin
      bus.axis_m_tvalid <= 1'b0;
    end
  end

  assign bus.busy = (state_q == ST_PKT);

endmodule

// File: tb/tb_aurora_axis_tx_arb.sv
// tb/tb_aurora_axis_tx_arb.sv - scoreboard bench for round-robin and select-mode arbiters
module tb_aurora_axis_tx_arb;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [1:0]  tid;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_a [2];
  logic [1:0]  sel_a [2];
  logic [3:0]  s_valid [2];
  logic [31:0] s_data [2][4];
  logic [3:0]  s_keep [2][4];
  logic [3:0]  s_last [2];
  logic        m_ready [2];
  logic [3:0]  s_ready [2];
  logic        m_valid [2];
  beat_t       m_beat [2];
  logic        busy_a [2];

  beat_t srcq [2][4][$];
  beat_t expq [2][$];
  int    acc_cnt [2][4];
  bit    at_start [2][4];
  int    trunc [2];
  bit    gap_chk [2];
  bit    gaps_en;
  int    rmode [2];
  int    total = 0;
  int    bad = 0;

  aurora_axis_tx_arb_if #(.CH_COUNT(4), .DATA_W(32), .SEL_W(2)) if0 ();
  aurora_axis_tx_arb_if #(.CH_COUNT(3), .DATA_W(32), .SEL_W(2)) if1 ();

  aurora_axis_tx_arb #(.CH_COUNT(4), .DATA_W(32), .SEL_W(2), .MODE(0)) u_rr (
    .clk (clk),
    .rstn(rstn_a[0]),
    .bus (if0)
  );

  aurora_axis_tx_arb #(.CH_COUNT(3), .DATA_W(32), .SEL_W(2), .MODE(1)) u_sel (
    .clk (clk),
    .rstn(rstn_a[1]),
    .bus (if1)
  );

  assign if0.axis_s_sel    = sel_a[0];
  assign if0.axis_s_tvalid = s_valid[0];
  assign if0.axis_s_tlast  = s_last[0];
  assign if0.axis_s_tdata  = {s_data[0][3], s_data[0][2], s_data[0][1], s_data[0][0]};
  assign if0.axis_s_tkeep  = {s_keep[0][3], s_keep[0][2], s_keep[0][1], s_keep[0][0]};
  assign if0.axis_m_tready = m_ready[0];
  assign if1.axis_s_sel    = sel_a[1];
  assign if1.axis_s_tvalid = s_valid[1][2:0];
  assign if1.axis_s_tlast  = s_last[1][2:0];
  assign if1.axis_s_tdata  = {s_data[1][2], s_data[1][1], s_data[1][0]};
  assign if1.axis_s_tkeep  = {s_keep[1][2], s_keep[1][1], s_keep[1][0]};
  assign if1.axis_m_tready = m_ready[1];

  assign s_ready[0] = if0.axis_s_tready;
  assign s_ready[1] = {1'b0, if1.axis_s_tready};
  assign m_valid[0] = if0.axis_m_tvalid;
  assign m_valid[1] = if1.axis_m_tvalid;
  assign m_beat[0]  = {if0.axis_m_tdata, if0.axis_m_tkeep, if0.axis_m_tlast, if0.axis_m_tid};
  assign m_beat[1]  = {if1.axis_m_tdata, if1.axis_m_tkeep, if1.axis_m_tlast, if1.axis_m_tid};
  assign busy_a[0]  = if0.busy;
  assign busy_a[1]  = if1.busy;

  // Packets are issued in the order the reference arbitration rules must emit them.
  task automatic send_pkt(input int d, input int c, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = $urandom;
      b.keep = 4'($urandom);
      b.last = (i == len - 1);
      b.tid  = 2'(c);
      srcq[d][c].push_back(b);
      expq[d].push_back(b);
    end
  endtask

  task automatic wait_empty(input int d, input int budget, input string what);
    int n;
    n = 0;
    while (expq[d].size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (expq[d].size() != 0) begin
      bad++;
      $display("FAIL %s drain: %0d beats outstanding, want 0", what, expq[d].size());
    end
  endtask

  task automatic check_zero(input int d, input string what);
    total++;
    if ({m_valid[d], m_beat[d], s_ready[d], busy_a[d]} !== '0) begin
      bad++;
      $display("FAIL %s: valid=%b beat=%h tready=%b busy=%b, want all 0",
               what, m_valid[d], m_beat[d], s_ready[d], busy_a[d]);
    end
  endtask

  // Source framers: hold a presented beat until accepted; gaps only inside packets.
  initial begin : driver
    logic [3:0] acc [2];
    beat_t b;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) acc[d] = s_valid[d] & s_ready[d];
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < 4; c++) begin
          if (acc[d][c]) begin
            b = srcq[d][c].pop_front();
            at_start[d][c] = b.last;
            acc_cnt[d][c]++;
            s_valid[d][c] = 1'b0;
          end
          if (!s_valid[d][c] && srcq[d][c].size() != 0) begin
            b = srcq[d][c][0];
            s_data[d][c] = b.data;
            s_keep[d][c] = b.keep;
            s_last[d][c] = b.last;
            if (at_start[d][c] || !gaps_en || $urandom_range(3) != 0) s_valid[d][c] = 1'b1;
          end
        end
      end
    end
  end

  initial begin : ready_gen
    logic [3:0] pat;
    int pidx;
    pat = 4'b1001;
    pidx = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        case (rmode[d])
          1:       m_ready[d] = pat[pidx % 4];
          2:       m_ready[d] = ($urandom_range(1) == 1);
          default: m_ready[d] = 1'b1;
        endcase
      end
      pidx++;
    end
  end

  initial begin : monitor
    int    cyc [2];
    int    last_cyc [2];
    bit    last_tl [2];
    bit    last_chk [2];
    bit    in_pkt [2];
    bit    stall_q [2];
    logic [39:0] held [2];
    beat_t exp_b;
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 0; last_cyc[d] = 0; last_tl[d] = 0; last_chk[d] = 0;
      in_pkt[d] = 0; stall_q[d] = 0; held[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        cyc[d]++;
        if (stall_q[d]) begin
          total++;
          if ({m_valid[d], m_beat[d]} !== held[d]) begin
            bad++;
            $display("FAIL stall%0d: got %h, held %h", d, {m_valid[d], m_beat[d]}, held[d]);
          end
        end
        if (m_valid[d] && m_ready[d]) begin
          total++;
          if (expq[d].size() == 0) begin
            bad++;
            $display("FAIL beat%0d: got unexpected %h, want none", d, m_beat[d]);
          end else begin
            exp_b = expq[d].pop_front();
            if (m_beat[d] !== exp_b) begin
              bad++;
              $display("FAIL beat%0d: got %h, want %h", d, m_beat[d], exp_b);
            end
          end
          if (gap_chk[d] && last_chk[d] && last_tl[d]) begin
            total++;
            if (cyc[d] - last_cyc[d] != 2) begin
              bad++;
              $display("FAIL gap%0d: got %0d cycles, want 2", d, cyc[d] - last_cyc[d]);
            end
          end
          last_cyc[d] = cyc[d];
          last_tl[d]  = m_beat[d].last;
          last_chk[d] = gap_chk[d];
          in_pkt[d]   = !m_beat[d].last;
        end
        if (!rstn_a[d] && in_pkt[d]) begin
          trunc[d]++;
          in_pkt[d] = 1'b0;
        end
        stall_q[d] = m_valid[d] && !m_ready[d] && rstn_a[d];
        held[d]    = {m_valid[d], m_beat[d]};
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int base;
    for (int d = 0; d < 2; d++) begin
      rstn_a[d] = 1'b0; sel_a[d] = 2'd3; s_valid[d] = '0; s_last[d] = '0;
      m_ready[d] = 1'b1; trunc[d] = 0; gap_chk[d] = 0; rmode[d] = 0;
      for (int c = 0; c < 4; c++) begin
        s_data[d][c] = '0; s_keep[d][c] = '0; acc_cnt[d][c] = 0; at_start[d][c] = 1;
      end
    end
    gaps_en = 0;

    // Reset with every channel requesting, then continuous 3-beat round-robin traffic.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) send_pkt(0, c, 3);
    repeat (3) begin
      @(negedge clk);
      check_zero(0, "reset_rr");
      check_zero(1, "reset_sel");
    end
    gap_chk[0] = 1;
    @(posedge clk);
    #1;
    rstn_a[0] = 1'b1;
    rstn_a[1] = 1'b1;
    wait_empty(0, 400, "rr_fair");
    gap_chk[0] = 0;

    // Fixed 1,0,0,1 backpressure, mid-packet source gaps, opening round of 5-beat packets.
    rmode[0] = 1;
    gaps_en  = 1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) send_pkt(0, c, (r == 0) ? 5 : int'($urandom_range(5, 1)));
    wait_empty(0, 2000, "bp_pattern");

    rmode[0] = 2;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) send_pkt(0, c, int'($urandom_range(6, 1)));
    wait_empty(0, 3000, "bp_random");
    rmode[0] = 0;
    gaps_en  = 0;

    // Single-beat packets from channel 1 only.
    gap_chk[0] = 1;
    for (int i = 0; i < 6; i++) send_pkt(0, 1, 1);
    wait_empty(0, 100, "single_beat");
    gap_chk[0] = 0;

    // Reset after beat 2 of a 4-beat packet; the tail becomes a new packet.
    base = acc_cnt[0][2];
    send_pkt(0, 2, 4);
    n = 0;
    while (acc_cnt[0][2] != base + 2 && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    total++;
    if (acc_cnt[0][2] != base + 2) begin
      bad++;
      $display("FAIL reset_mid wait: accepted %0d, want %0d", acc_cnt[0][2] - base, 2);
    end
    rstn_a[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_zero(0, "reset_mid_a");
    @(negedge clk);
    check_zero(0, "reset_mid_b");
    @(posedge clk);
    #1;
    rstn_a[0] = 1'b1;
    wait_empty(0, 100, "reset_tail");
    total++;
    if (trunc[0] != 1) begin
      bad++;
      $display("FAIL truncated_pkt: got %0d, want 1", trunc[0]);
    end

    // External select: ch2 packet completes despite a mid-packet change to ch1.
    sel_a[1] = 2'd2;
    send_pkt(1, 2, 6);
    send_pkt(1, 1, 4);
    n = 0;
    while (!busy_a[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!busy_a[1]) begin
      bad++;
      $display("FAIL sel_grant: busy=%b, want 1", busy_a[1]);
    end
    repeat (2) @(posedge clk);
    #1;
    sel_a[1] = 2'd1;
    wait_empty(1, 200, "sel_switch");

    // Out-of-range select never grants.
    sel_a[1] = 2'd3;
    send_pkt(1, 0, 2);
    repeat (10) begin
      @(negedge clk);
      total++;
      if (busy_a[1] || m_valid[1]) begin
        bad++;
        $display("FAIL sel_oor: busy=%b valid=%b, want 0 0", busy_a[1], m_valid[1]);
      end
    end
    @(posedge clk);
    #1;
    sel_a[1] = 2'd0;
    wait_empty(1, 100, "sel_ch0");

    repeat (4) @(negedge clk);
    total++;
    if (busy_a[0] || busy_a[1]) begin
      bad++;
      $display("FAIL final_idle: busy=%b%b, want 00", busy_a[0], busy_a[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
